// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and its neighbour control FSM:
// PCSource encodings, fetch FSM states, IR field positions and the NOP word.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'd0,
    PCSRC_ALU    = 2'd1,
    PCSRC_ALUOUT = 2'd2,
    PCSRC_JUMP   = 2'd3
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } fetch_state_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Jump target keeps the PC's top bits and takes IR[11:0] as a halfword index.
  localparam int JUMP_FIELD_W = 12;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: the fetch unit is master, the memory is slave.
interface fetch_unit_if #(
  parameter int WIDTH = 16
) ();

  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/fetch_unit_pc_next_mux.sv
// Next-PC selection: sequential increment, ALU result, registered ALU output
// or the jump target built from the current IR.
module fetch_unit_pc_next_mux
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PC_STEP = 2
) (
  input  pcsrc_e                  pc_source_i,
  input  logic [WIDTH-1:0]        pc_i,
  input  logic [WIDTH-1:0]        alu_result_i,
  input  logic [WIDTH-1:0]        alu_out_i,
  input  logic [JUMP_FIELD_W-1:0] jump_field_i,
  output logic [WIDTH-1:0]        pc_next_o
);

  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_jump;

  // Plain WIDTH-bit add: the increment wraps modulo 2^WIDTH.
  assign pc_seq  = pc_i + WIDTH'(PC_STEP);
  assign pc_jump = {pc_i[WIDTH-1:JUMP_FIELD_W+1], jump_field_i, 1'b0};

  always_comb begin
    unique case (pc_source_i)
      PCSRC_SEQ:    pc_next_o = pc_seq;
      PCSRC_ALU:    pc_next_o = alu_result_i;
      PCSRC_ALUOUT: pc_next_o = alu_out_i;
      PCSRC_JUMP:   pc_next_o = pc_jump;
      default:      pc_next_o = pc_seq;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns PC and IR, runs the instruction-memory read handshake and
// decodes IR fields. FETCH_TIMEOUT_EN adds a wait-cycle limit and fetch_err.
module fetch_unit #(
  parameter int               WIDTH     = 16,
  parameter int               PC_STEP   = 2,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int               MAX_WAIT  = 15
`endif
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             IRWrite,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             Zero,
  input  logic [1:0]       PCSource,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] ALUOut,
  fetch_unit_if.master     mem,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] IR,
  output logic [3:0]       op,
  output logic [3:0]       rd,
  output logic [3:0]       rs,
  output logic [3:0]       rt,
  output logic [7:0]       imm,
  output logic             ir_valid,
  output logic             Stall,
  output logic             fetch_err
);

  import fetch_unit_pkg::*;

  fetch_state_e     state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] addr_q;
  logic             req_q;
  logic             valid_q;
  logic             stall_q;
  logic [WIDTH-1:0] pc_next;
  logic             pc_en;
  logic             wait_timeout;

  fetch_unit_pc_next_mux #(
    .WIDTH   (WIDTH),
    .PC_STEP (PC_STEP)
  ) u_pc_next_mux (
    .pc_source_i  (pcsrc_e'(PCSource)),
    .pc_i         (pc_q),
    .alu_result_i (ALUResult),
    .alu_out_i    (ALUOut),
    .jump_field_i (ir_q[JUMP_FIELD_W-1:0]),
    .pc_next_o    (pc_next)
  );

  assign pc_en = PCWrite | (PCWriteCond & Zero);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what lets mem_addr capture the old PC
  // while PC takes its new value on the same edge.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q <= RESET_PC;
    end else if (pc_en) begin
      pc_q <= pc_next;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;
  logic       fetch_err_q;

  assign wait_cnt_d   = wait_cnt_q + 4'd1;
  assign wait_timeout = (state_q == ST_WAIT) && !mem.mem_ready && (wait_cnt_d == MAX_WAIT_C);

  // Counter is held at zero outside WAIT, so it starts clean on every entry.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_d : 4'd0;
      if (wait_timeout) begin
        fetch_err_q <= 1'b1;
      end
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign wait_timeout = 1'b0;
  assign fetch_err    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      ir_q    <= NOP_INSTR;
      addr_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        // LOAD accepts a new IRWrite exactly like IDLE for back-to-back fetches.
        ST_IDLE, ST_LOAD: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
          if (IRWrite) begin
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            stall_q <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem.mem_ready) begin
            ir_q    <= mem.mem_rdata;
            req_q   <= 1'b0;
            stall_q <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_LOAD;
          end else if (wait_timeout) begin
            ir_q    <= NOP_INSTR;
            req_q   <= 1'b0;
            stall_q <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  assign PC       = pc_q;
  assign IR       = ir_q;
  assign ir_valid = valid_q;
  assign Stall    = stall_q;

  assign op  = ir_q[OP_MSB:OP_LSB];
  assign rd  = ir_q[RD_MSB:RD_LSB];
  assign rs  = ir_q[RS_MSB:RS_LSB];
  assign rt  = ir_q[RT_MSB:RT_LSB];
  assign imm = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the stimulus pushes expected IR loads into a
// queue and a negedge monitor pops and compares whenever ir_valid is seen.
module tb_fetch_unit;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] ir;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Zero;
  logic [1:0]  PCSource;
  logic [15:0] ALUResult;
  logic [15:0] ALUOut;
  logic [15:0] PC;
  logic [15:0] IR;
  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [7:0]  imm;
  logic        ir_valid;
  logic        Stall;
  logic        fetch_err;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t exp_q[$];

  fetch_unit_if #(.WIDTH(16)) mem_bus ();

  fetch_unit dut (
    .CLK         (clk),
    .Reset       (rst_n),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .Zero        (Zero),
    .PCSource    (PCSource),
    .ALUResult   (ALUResult),
    .ALUOut      (ALUOut),
    .mem         (mem_bus),
    .PC          (PC),
    .IR          (IR),
    .op          (op),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .ir_valid    (ir_valid),
    .Stall       (Stall),
    .fetch_err   (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at the negedge; outputs are observed at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_load(input logic [15:0] addr, input logic [15:0] ir);
    exp_t e;
    e.addr = addr;
    e.ir   = ir;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ir_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected ir_valid", 32'(ir_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb IR",       32'(IR),       32'(e.ir));
        check("sb mem_addr", 32'(mem_bus.mem_addr), 32'(e.addr));
        check("sb op",       32'(op),       32'(e.ir[15:12]));
        check("sb rd",       32'(rd),       32'(e.ir[11:8]));
        check("sb rs",       32'(rs),       32'(e.ir[7:4]));
        check("sb rt",       32'(rt),       32'(e.ir[3:0]));
        check("sb imm",      32'(imm),      32'(e.ir[7:0]));
        check("sb Stall",    32'(Stall),    32'd0);
      end
    end
  end

  initial begin
    rst_n             = 1'b0;
    IRWrite           = 1'b0;
    PCWrite           = 1'b0;
    PCWriteCond       = 1'b0;
    Zero              = 1'b0;
    PCSource          = 2'd0;
    ALUResult         = 16'h0000;
    ALUOut            = 16'h0000;
    mem_bus.mem_rdata = 16'h0000;
    mem_bus.mem_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst PC",        32'(PC),                16'h0000);
    check("rst IR",        32'(IR),                16'h0000);
    check("rst mem_addr",  32'(mem_bus.mem_addr),  16'h0000);
    check("rst mem_req",   32'(mem_bus.mem_req),   32'd0);
    check("rst ir_valid",  32'(ir_valid),          32'd0);
    check("rst Stall",     32'(Stall),             32'd0);
    check("rst fetch_err", 32'(fetch_err),         32'd0);
    rst_n = 1'b1;

    // Zero-wait fetch of 16'h1234 from address 0
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    check("f1 mem_req",  32'(mem_bus.mem_req),  32'd1);
    check("f1 mem_addr", 32'(mem_bus.mem_addr), 16'h0000);
    check("f1 Stall",    32'(Stall),            32'd1);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'h1234;
    expect_load(16'h0000, 16'h1234);
    step();
    mem_bus.mem_ready = 1'b0;
    check("f1 ir_valid", 32'(ir_valid), 32'd1);
    check("f1 op",       32'(op),       32'd1);
    check("f1 rd",       32'(rd),       32'd2);
    check("f1 rs",       32'(rs),       32'd3);
    check("f1 rt",       32'(rt),       32'd4);
    step();
    check("f1 ir_valid drop", 32'(ir_valid), 32'd0);

    // IRWrite with PCWrite: old PC goes to mem_addr, PC advances
    PCWrite   = 1'b1;
    PCSource  = 2'd1;
    ALUResult = 16'h0010;
    step();
    check("pc alu", 32'(PC), 16'h0010);
    IRWrite  = 1'b1;
    PCSource = 2'd0;
    step();
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    check("same-cycle mem_addr", 32'(mem_bus.mem_addr), 16'h0010);
    check("same-cycle PC",       32'(PC),               16'h0012);

    // Slow memory: bus stable, IRWrite pulses during WAIT ignored
    for (int i = 0; i < 5; i++) begin
      IRWrite = (i % 2 == 0);
      step();
      check("wait mem_req",  32'(mem_bus.mem_req),  32'd1);
      check("wait mem_addr", 32'(mem_bus.mem_addr), 16'h0010);
      check("wait Stall",    32'(Stall),            32'd1);
    end
    IRWrite           = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'hA5C3;
    expect_load(16'h0010, 16'hA5C3);
    step();
    mem_bus.mem_ready = 1'b0;
    step();
    check("no queued fetch req",   32'(mem_bus.mem_req), 32'd0);
    check("no queued fetch Stall", 32'(Stall),           32'd0);

    // mem_ready in IDLE is ignored
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'hFFFF;
    step();
    mem_bus.mem_ready = 1'b0;
    check("idle ready IR",       32'(IR),       16'hA5C3);
    check("idle ready ir_valid", 32'(ir_valid), 32'd0);

    // Conditional PC write
    PCWriteCond = 1'b1;
    PCSource    = 2'd2;
    ALUOut      = 16'h0040;
    Zero        = 1'b0;
    step();
    check("cond Zero=0 PC", 32'(PC), 16'h0012);
    Zero = 1'b1;
    step();
    check("cond Zero=1 PC", 32'(PC), 16'h0040);
    PCWriteCond = 1'b0;
    Zero        = 1'b0;

    // Sequential increment wraps
    PCWrite   = 1'b1;
    PCSource  = 2'd1;
    ALUResult = 16'hFFFE;
    step();
    PCSource = 2'd0;
    step();
    PCWrite = 1'b0;
    check("pc wrap", 32'(PC), 16'h0000);

    // Load IR=16'h2ABC for the jump test
    IRWrite = 1'b1;
    step();
    IRWrite           = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'h2ABC;
    expect_load(16'h0000, 16'h2ABC);
    step();
    mem_bus.mem_ready = 1'b0;
    step();

    // Jump during a fetch uses the current IR, then a back-to-back fetch
    PCWrite   = 1'b1;
    PCSource  = 2'd1;
    ALUResult = 16'h8000;
    step();
    PCWrite = 1'b0;
    check("pc 8000", 32'(PC), 16'h8000);
    IRWrite = 1'b1;
    step();
    IRWrite  = 1'b0;
    PCWrite  = 1'b1;
    PCSource = 2'd3;
    step();
    PCWrite = 1'b0;
    check("jump PC",           32'(PC),               16'h9578);
    check("jump in-flight addr", 32'(mem_bus.mem_addr), 16'h8000);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'h3FFF;
    expect_load(16'h8000, 16'h3FFF);
    step();
    mem_bus.mem_ready = 1'b0;
    IRWrite           = 1'b1;
    step();
    IRWrite = 1'b0;
    check("b2b mem_req",  32'(mem_bus.mem_req),  32'd1);
    check("b2b mem_addr", 32'(mem_bus.mem_addr), 16'h9578);
    check("b2b Stall",    32'(Stall),            32'd1);
    check("b2b IR held",  32'(IR),               16'h3FFF);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'h7001;
    expect_load(16'h9578, 16'h7001);
    step();
    mem_bus.mem_ready = 1'b0;
    step();

    // Memory that never answers
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    expect_load(16'h9578, 16'h0000);
    for (int i = 0; i < 14; i++) step();
    check("pre-timeout Stall",     32'(Stall),     32'd1);
    check("pre-timeout fetch_err", 32'(fetch_err), 32'd0);
    step();
    check("timeout ir_valid",  32'(ir_valid),  32'd1);
    check("timeout fetch_err", 32'(fetch_err), 32'd1);
    step();
    check("fetch_err sticky",  32'(fetch_err), 32'd1);
`else
    for (int i = 0; i < 20; i++) step();
    check("long wait Stall",     32'(Stall),            32'd1);
    check("long wait mem_req",   32'(mem_bus.mem_req),  32'd1);
    check("long wait fetch_err", 32'(fetch_err),        32'd0);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'h5A5A;
    expect_load(16'h9578, 16'h5A5A);
    step();
    mem_bus.mem_ready = 1'b0;
    step();
`endif

    // Reset in the middle of a fetch aborts it; a late mem_ready is ignored
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    check("pre-abort mem_req", 32'(mem_bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort mem_req",   32'(mem_bus.mem_req), 32'd0);
    check("abort Stall",     32'(Stall),           32'd0);
    check("abort IR",        32'(IR),              16'h0000);
    check("abort PC",        32'(PC),              16'h0000);
    check("abort fetch_err", 32'(fetch_err),       32'd0);
    @(negedge clk);
    rst_n             = 1'b1;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'hBEEF;
    step();
    step();
    mem_bus.mem_ready = 1'b0;
    check("late ready IR",      32'(IR),              16'h0000);
    check("late ready mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("late ready Stall",   32'(Stall),           32'd0);

    step();
    step();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
